lcd_timing_gen: RTL and testbench

- Drives the RGB LCD side of the panel interface: pins, bus direction, sync/DE timing and pixel request.
- After reset it releases `lcd_rgb` so the panel-ID strap reader can sample M2/M1/M0.
- It then takes the latched panel ID and selects that panel's timing set.
- It runs the raster: hsync, vsync, DE and the pixel fetch coordinates. It sits between the ID reader, the frame-buffer read logic and the LCD pins.

---
 rtl/lcd_pkg.sv | 48 ++++
 rtl/lcd_timing_gen_if.sv | 15 +
 rtl/lcd_raster_cnt.sv | 55 +++++
 rtl/lcd_timing_gen.sv | 78 +++++++
 tb/tb_lcd_timing_gen.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: panel IDs, timing-set record, controller states
// and the ID-to-timing decode.
package lcd_pkg;

    localparam logic [15:0] ID_4342 = 16'h4342;
    localparam logic [15:0] ID_7084 = 16'h7084;
    localparam logic [15:0] ID_7016 = 16'h7016;
    localparam logic [15:0] ID_4384 = 16'h4384;
    localparam logic [15:0] ID_1018 = 16'h1018;

    typedef struct packed {
        logic [10:0] h_sync;
        logic [10:0] h_back;
        logic [10:0] h_disp;
        logic [10:0] h_total;
        logic [10:0] v_sync;
        logic [10:0] v_back;
        logic [10:0] v_disp;
        logic [10:0] v_total;
    } lcd_tset_t;

    typedef enum logic [1:0] {
        ST_RELEASE,
        ST_WAIT_ID,
        ST_RUN,
        ST_UNSUPP
    } lcd_state_t;

    // Unknown IDs decode to an all-zero set; lcd_id_known() gates its use.
    function automatic lcd_tset_t lcd_timing(input logic [15:0] id);
        lcd_tset_t t;
        t = '0;
        case (id)
            ID_4342:          t = '{11'd41,  11'd2,   11'd480,  11'd525,  11'd10, 11'd2,  11'd272, 11'd286};
            ID_7084, ID_4384: t = '{11'd128, 11'd88,  11'd800,  11'd1056, 11'd2,  11'd33, 11'd480, 11'd525};
            ID_7016:          t = '{11'd20,  11'd140, 11'd1024, 11'd1344, 11'd3,  11'd20, 11'd600, 11'd635};
            ID_1018:          t = '{11'd10,  11'd80,  11'd1280, 11'd1440, 11'd3,  11'd10, 11'd800, 11'd823};
            default:          t = '0;
        endcase
        return t;
    endfunction

    function automatic logic lcd_id_known(input logic [15:0] id);
        return (id == ID_4342) || (id == ID_7084) || (id == ID_7016) ||
               (id == ID_4384) || (id == ID_1018);
    endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Panel-ID and pixel-fetch signals between the timing generator (master)
// and the ID reader / frame-buffer read logic (slave).
interface lcd_timing_gen_if;
    logic [15:0] lcd_id;
    logic        id_valid;
    logic        data_req;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [15:0] pixel_data;

    modport master (input lcd_id, id_valid, pixel_data,
                    output data_req, pixel_xpos, pixel_ypos);
    modport slave  (output lcd_id, id_valid, pixel_data,
                    input data_req, pixel_xpos, pixel_ypos);
endinterface

// File: rtl/lcd_raster_cnt.sv
// Horizontal/vertical raster counters with active-region and sync decodes.
// Counters sit at zero while en is low, so the first enabled cycle is (0,0).
module lcd_raster_cnt
    import lcd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  lcd_tset_t   tset,
    output logic        data_req,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        de,
    output logic        hs,
    output logic        vs
);
    logic [10:0] h_cnt, v_cnt;
    logic [10:0] h_start, v_start;
    logic        h_act, v_act;

    assign h_start = tset.h_sync + tset.h_back;
    assign v_start = tset.v_sync + tset.v_back;
    assign h_act   = (h_cnt >= h_start) && (h_cnt < h_start + tset.h_disp);
    assign v_act   = (v_cnt >= v_start) && (v_cnt < v_start + tset.v_disp);

    assign data_req = en && h_act && v_act;
    assign xpos     = data_req ? h_cnt - h_start : 11'd0;
    assign ypos     = data_req ? v_cnt - v_start : 11'd0;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == tset.h_total - 11'd1) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == tset.v_total - 11'd1) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    // Pin-side decodes are registered: they trail data_req by one cycle,
    // which gives the fetch logic its cycle to return pixel_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            de <= 1'b0;
            hs <= 1'b1;
            vs <= 1'b1;
        end else begin
            de <= data_req;
            hs <= !(en && (h_cnt < tset.h_sync));
            vs <= !(en && (v_cnt < tset.v_sync));
        end
    end
endmodule

// File: rtl/lcd_timing_gen.sv
// RGB LCD timing generator: releases the bus for strap sampling, selects a
// timing set from the latched panel ID, then runs the raster.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int STRAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    lcd_timing_gen_if.master  pif,
    output logic [10:0]       h_disp,
    output logic [10:0]       v_disp,
    output logic [15:0]       lcd_rgb_o,
    output logic              lcd_rgb_oe,
    output logic              lcd_de,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_bl,
    output logic              lcd_rst,
    output logic              lcd_clk
);
    localparam int SC_W = $clog2(STRAP_CYCLES);

    lcd_state_t      state, state_nxt;
    logic [SC_W-1:0] strap_cnt;
    lcd_tset_t       tset;
    logic            run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RELEASE;
            strap_cnt <= '0;
            tset      <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_RELEASE)
                strap_cnt <= strap_cnt + 1'b1;
            // Latched once on the way into RUN; later lcd_id changes are ignored.
            if (state == ST_WAIT_ID && pif.id_valid)
                tset <= lcd_timing(pif.lcd_id);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RELEASE: if (strap_cnt == SC_W'(STRAP_CYCLES - 1)) state_nxt = ST_WAIT_ID;
            ST_WAIT_ID: if (pif.id_valid)
                            state_nxt = lcd_id_known(pif.lcd_id) ? ST_RUN : ST_UNSUPP;
            ST_RUN:     state_nxt = ST_RUN;
            ST_UNSUPP:  state_nxt = ST_UNSUPP;
            default:    state_nxt = ST_RELEASE;
        endcase
    end

    assign run = (state == ST_RUN);

    lcd_raster_cnt u_raster (
        .clk      (clk),
        .rst      (rst),
        .en       (run),
        .tset     (tset),
        .data_req (pif.data_req),
        .xpos     (pif.pixel_xpos),
        .ypos     (pif.pixel_ypos),
        .de       (lcd_de),
        .hs       (lcd_hs),
        .vs       (lcd_vs)
    );

    assign h_disp     = run ? tset.h_disp : 11'd0;
    assign v_disp     = run ? tset.v_disp : 11'd0;
    assign lcd_rgb_o  = lcd_de ? pif.pixel_data : 16'h0000;
    assign lcd_rgb_oe = run;
    assign lcd_bl     = run;
    assign lcd_rst    = run;
    assign lcd_clk    = clk;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: per-panel vector table plus sequences
// for strap release, first/last fetch, pixel path and mid-line reset.
module tb_lcd_timing_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] h_disp, v_disp;
    logic [15:0] lcd_rgb_o;
    logic        lcd_rgb_oe, lcd_de, lcd_hs, lcd_vs, lcd_bl, lcd_rst, lcd_clk;

    int errors = 0;
    int checks = 0;

    lcd_timing_gen_if ifc ();

    lcd_timing_gen #(.STRAP_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .pif        (ifc),
        .h_disp     (h_disp),
        .v_disp     (v_disp),
        .lcd_rgb_o  (lcd_rgb_o),
        .lcd_rgb_oe (lcd_rgb_oe),
        .lcd_de     (lcd_de),
        .lcd_hs     (lcd_hs),
        .lcd_vs     (lcd_vs),
        .lcd_bl     (lcd_bl),
        .lcd_rst    (lcd_rst),
        .lcd_clk    (lcd_clk)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [10:0] x, input logic [10:0] y);
        return {x, y[4:0]} ^ 16'h5a5a;
    endfunction

    // Frame-buffer read model: answers a request one cycle later.
    always @(posedge clk)
        ifc.pixel_data <= ifc.data_req ? pat(ifc.pixel_xpos, ifc.pixel_ypos) : 16'h0000;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset(input logic [15:0] id, input logic vld);
        @(negedge clk);
        rst = 1'b1;
        ifc.lcd_id = id;
        ifc.id_valid = vld;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (!lcd_rgb_oe && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Counts pin activity over the next ncyc cycles.
    task automatic count_win(input int ncyc, output int hs_lo, output int vs_lo, output int de_n);
        hs_lo = 0; vs_lo = 0; de_n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (!lcd_hs) hs_lo++;
            if (!lcd_vs) vs_lo++;
            if (lcd_de)  de_n++;
        end
    endtask

    typedef struct {
        logic [15:0] id;
        bit          known;
        int          hdisp, vdisp, htotal, hsync;
        int          vdelay;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   n, hs_lo, vs_lo, de_n, bad, prev_req;
        logic [15:0] prev_pat;

        tbl[0] = '{16'h4342, 1'b1, 480,  272, 525,  41,  0};
        tbl[1] = '{16'h7084, 1'b1, 800,  480, 1056, 128, 0};
        tbl[2] = '{16'h7016, 1'b1, 1024, 600, 1344, 20,  0};
        tbl[3] = '{16'h4384, 1'b1, 800,  480, 1056, 128, 40};
        tbl[4] = '{16'h1018, 1'b1, 1280, 800, 1440, 10,  0};
        tbl[5] = '{16'h1234, 1'b0, 0,    0,   0,    0,   0};

        ifc.lcd_id = 16'h4342;
        ifc.id_valid = 1'b1;

        // Reset values, strap release length, first hsync, latched set.
        @(negedge clk);
        @(negedge clk);
        chk("rst_pins", int'({lcd_rgb_oe, lcd_de, lcd_hs, lcd_vs, lcd_bl, lcd_rst, ifc.data_req}), 'b0011000);
        chk("rst_hdisp", int'(h_disp), 0);
        chk("rst_rgb", int'(lcd_rgb_o), 0);
        rst = 1'b0;
        wait_run(n);
        chk("strap_release_cycles", n, 17);
        chk("run_hs_first_cycle", int'(lcd_hs), 1);
        chk("run_hdisp_4342", int'(h_disp), 480);
        count_win(21 * 525, hs_lo, vs_lo, de_n);
        chk("hs_low_4342_21lines", hs_lo, 21 * 41);
        chk("vs_low_4342", vs_lo, 10 * 525);
        chk("de_4342_rows12to20", de_n, 9 * 480);
        ifc.lcd_id = 16'h1018;
        repeat (5) @(negedge clk);
        chk("tset_latched_hdisp", int'(h_disp), 480);
        chk("tset_latched_vdisp", int'(v_disp), 272);

        // Vector table: one line of timing per panel ID.
        foreach (tbl[k]) begin
            do_reset(tbl[k].id, tbl[k].vdelay == 0);
            if (!tbl[k].known) begin
                bad = 0;
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (lcd_rgb_oe || lcd_bl || lcd_de || ifc.data_req || !lcd_hs || !lcd_vs) bad++;
                end
                chk("unsupp_idle_cycles", bad, 0);
                chk("unsupp_hdisp", int'(h_disp), 0);
            end else begin
                n = 0;
                if (tbl[k].vdelay != 0) begin
                    repeat (tbl[k].vdelay) @(negedge clk);
                    n = tbl[k].vdelay;
                    ifc.id_valid = 1'b1;
                end
                begin
                    int w;
                    wait_run(w);
                    n += w;
                end
                chk("tbl_run_entry", n, 17 + ((tbl[k].vdelay != 0) ? tbl[k].vdelay - 16 : 0));
                chk("tbl_pins_on", int'({lcd_rgb_oe, lcd_bl, lcd_rst}), 'b111);
                chk("tbl_hdisp", int'(h_disp), tbl[k].hdisp);
                chk("tbl_vdisp", int'(v_disp), tbl[k].vdisp);
                count_win(tbl[k].htotal, hs_lo, vs_lo, de_n);
                chk("tbl_hs_low_per_line", hs_lo, tbl[k].hsync);
            end
        end

        // 0x1018: first and last request of the first active row.
        do_reset(16'h1018, 1'b1);
        wait_run(n);
        n = 0;
        while (!ifc.data_req && n < 30000) begin
            n++;
            @(negedge clk);
        end
        chk("first_req_1018_delay", n, 13 * 1440 + 90);
        chk("first_req_xpos", int'(ifc.pixel_xpos), 0);
        chk("first_req_ypos", int'(ifc.pixel_ypos), 0);
        repeat (1279) @(negedge clk);
        chk("row_end_req", int'(ifc.data_req), 1);
        chk("row_end_xpos", int'(ifc.pixel_xpos), 1279);
        @(negedge clk);
        chk("after_row_req", int'({ifc.data_req, ifc.pixel_xpos}), 0);

        // 0x7084: pixel path through the first two active rows.
        do_reset(16'h7084, 1'b1);
        wait_run(n);
        bad = 0; de_n = 0; hs_lo = 0; vs_lo = 0;
        prev_req = int'(ifc.data_req);
        prev_pat = pat(ifc.pixel_xpos, ifc.pixel_ypos);
        for (int i = 0; i < 37 * 1056; i++) begin
            @(negedge clk);
            if (int'(lcd_de) != prev_req) bad++;
            if (lcd_rgb_o != (lcd_de ? prev_pat : 16'h0000)) bad++;
            if (lcd_de)  de_n++;
            if (!lcd_hs) hs_lo++;
            if (!lcd_vs) vs_lo++;
            prev_req = int'(ifc.data_req);
            prev_pat = pat(ifc.pixel_xpos, ifc.pixel_ypos);
        end
        chk("rgb_path_bad_cycles", bad, 0);
        chk("de_7084_rows35_36", de_n, 2 * 800);
        chk("hs_low_7084_37lines", hs_lo, 37 * 128);
        chk("vs_low_7084", vs_lo, 2 * 1056);

        // Mid-line reset, then a different panel ID.
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pins", int'({lcd_rgb_oe, lcd_de, lcd_hs, lcd_vs, lcd_bl, lcd_rst, ifc.data_req}), 'b0011000);
        chk("midrst_disp", int'({h_disp, v_disp}), 0);
        chk("midrst_rgb", int'(lcd_rgb_o), 0);
        ifc.lcd_id = 16'h7016;
        rst = 1'b0;
        wait_run(n);
        chk("midrst_rerelease_cycles", n, 17);
        chk("midrst_hdisp_7016", int'(h_disp), 1024);
        chk("midrst_vdisp_7016", int'(v_disp), 600);
        count_win(4 * 1344, hs_lo, vs_lo, de_n);
        chk("hs_low_7016_4lines", hs_lo, 4 * 20);
        chk("vs_low_7016", vs_lo, 3 * 1344);
        chk("de_7016_blank_rows", de_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
